// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU front end: PC width,
// PC-unit state encoding and the reset fetch address.
package cpu_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } pc_state_t;

    localparam logic [PC_W-1:0] PC_RESET = '0;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-address arithmetic: PC + 4 and the branch/jump target
// PC + 4 + (sign-extended word offset * 4), both modulo 2^PC_W.
module pc_target_adder
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W
) (
    input  logic               [PC_W-1:0] pc,
    input  logic signed        [7:0]      offset,
    output logic               [PC_W-1:0] pc_plus4,
    output logic               [PC_W-1:0] target
);

    logic signed [PC_W-1:0] offset_bytes;

    // Word offset becomes a byte offset; the two appended zeros keep targets aligned.
    assign offset_bytes = {{(PC_W-10){offset[7]}}, offset, 2'b00};
    assign pc_plus4     = pc + PC_W'(4);
    assign target       = pc_plus4 + $unsigned(offset_bytes);

endmodule

// File: rtl/pc_unit.sv
// Program counter and next-PC selection with memory-stall handling and a
// saturating count of taken branches/jumps.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W  = cpu_pkg::PC_W,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ZERO,
    input  logic              BRANCH,
    input  logic              BNE,
    input  logic              JUMP,
    input  logic [7:0]        OFFSET,
    input  logic              BUSYWAIT,
    output logic [PC_W-1:0]   PC,
    output logic [PC_W-1:0]   PC_PLUS4,
    output logic              INSTR_VALID,
    output logic [CNT_W-1:0]  TAKEN_CNT
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pc_state_t         state_p0;
    pc_state_t         state_nxt;
    logic [PC_W-1:0]   pc_p0;
    logic [CNT_W-1:0]  taken_cnt_p0;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   next_pc;
    logic              take;
    logic              load_pc;
    logic              vld_p0;

    pc_target_adder #(
        .PC_W (PC_W)
    ) u_adder (
        .pc       (pc_p0),
        .offset   (OFFSET),
        .pc_plus4 (pc_plus4),
        .target   (target)
    );

    assign take    = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
    assign next_pc = take ? target : pc_plus4;

    // STALL never loads the PC, so a stalled branch is evaluated (and counted)
    // only on the RUN edge where memory is ready.
    always_comb begin
        state_nxt = state_p0;
        load_pc   = 1'b0;
        vld_p0    = 1'b0;
        case (state_p0)
            ST_RST: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                vld_p0 = 1'b1;
                if (BUSYWAIT) begin
                    state_nxt = ST_STALL;
                end else begin
                    load_pc = 1'b1;
                end
            end
            ST_STALL: begin
                if (!BUSYWAIT) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    // ---- stage p0: architectural PC, FSM state and taken counter ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_p0     <= ST_RST;
            pc_p0        <= PC_W'(PC_RESET);
            taken_cnt_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (load_pc) begin
                pc_p0 <= {next_pc[PC_W-1:2], 2'b00};
                if (take) begin
                    taken_cnt_p0 <= sat_inc(taken_cnt_p0);
                end
            end
        end
    end

    assign PC          = pc_p0;
    assign PC_PLUS4    = pc_plus4;
    assign INSTR_VALID = vld_p0;
    assign TAKEN_CNT   = taken_cnt_p0;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter and next-PC stage of the 8-bit single-cycle CPU, sitting directly downstream of the ALU.
- Consumes the ALU ZERO flag plus decoded branch/jump controls, computes the next instruction address and holds it in the PC register.
- Stalls while instruction or data memory asserts BUSYWAIT.
- Reports fetch validity and a saturating taken-branch count for the testbench and performance checks.

Parameters:
- PC_W, 32, PC width in bits; byte-addressed, word-aligned.
- CNT_W, 16, width of the taken-branch/jump counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ZERO  input  1  ALU equality flag (1 when DATA1 == DATA2).
- BRANCH  input  1  current instruction is beq.
- BNE  input  1  current instruction is bne; mutually exclusive with BRANCH.
- JUMP  input  1  current instruction is j; unconditional.
- OFFSET  input  8  signed word offset from instruction bits [23:16].
- BUSYWAIT  input  1  memory not ready; freezes the PC.
- PC  output  PC_W  address of the current instruction.
- PC_PLUS4  output  PC_W  PC + 4, combinational.
- INSTR_VALID  output  1  PC holds a fetchable instruction this cycle.
- TAKEN_CNT  output  CNT_W  number of taken branches and jumps since reset, saturating.

Behaviour:
- Reset, applied synchronously while RESET is 1 at a rising edge: PC = 0, TAKEN_CNT = 0, INSTR_VALID = 0, state = RST.
- RESET has priority over every other input, including mid-stall and mid-branch.
- Arithmetic:
  - PC_PLUS4 = PC + 4, modulo 2^PC_W.
  - target = PC_PLUS4 + (sign_extend(OFFSET) << 2), modulo 2^PC_W; no overflow flag.
  - Example: OFFSET 0xFF gives target = PC.
- take = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO).
- If JUMP and BRANCH are both asserted, JUMP wins; the target is the same, so the counter increments once.
- next_pc = take ? target : PC_PLUS4.
- State machine (2-bit state):
  - RST: entered on reset. The next edge with RESET=0 goes to RUN; PC stays 0. INSTR_VALID = 0.
  - RUN: INSTR_VALID = 1. Each edge with BUSYWAIT=0 loads PC <= next_pc, and TAKEN_CNT increments if take. An edge with BUSYWAIT=1 goes to STALL; PC and TAKEN_CNT are held.
  - STALL: INSTR_VALID = 0. PC and TAKEN_CNT are held and control inputs are ignored. The edge with BUSYWAIT=0 returns to RUN without updating PC.
  - STALL behaviour: the instruction at PC is re-executed and its branch is re-evaluated in RUN, so a stalled branch is counted once.
- Latency: PC changes one edge after the instruction is decoded. ZERO must be stable before the edge; the block registers no ALU output.
- TAKEN_CNT saturates at 2^CNT_W - 1 and never wraps.
- PC wrap: 0xFFFFFFFC + 4 = 0x00000000 with no error.
- PC bits [1:0] are always 0.
- No combinational path from BUSYWAIT to PC; PC_PLUS4 depends only on PC.

Decomposition:
- Shared package cpu_pkg: PC_W, state encoding (ST_RST=2'd0, ST_RUN=2'd1, ST_STALL=2'd2), and PC_RESET = 0.
- One natural sub-module: pc_target_adder, the combinational PC+4 and sign-extended, shifted offset adder.
- The FSM, PC register and counter stay in pc_unit.

Test Plan:
- Reset then release; no controls, BUSYWAIT=0 for 3 edges -> PC goes 0 (RST), 0, 4, 8; INSTR_VALID goes 0, 1, 1, 1; TAKEN_CNT = 0.
- PC=8, BRANCH=1, ZERO=1, OFFSET=0x02 -> PC=0x14, TAKEN_CNT=1. Repeat with ZERO=0 -> PC=0x0C, TAKEN_CNT unchanged.
- PC=0x20, BNE=1, ZERO=0, OFFSET=0xFE -> PC=0x1C. JUMP=1 and BRANCH=1 together, OFFSET=0x01 -> PC=PC+8, TAKEN_CNT increments by exactly 1.
- PC=0x10, JUMP=1, BUSYWAIT=1 for 3 edges then 0 -> PC stays 0x10 and INSTR_VALID=0 during the stall. The next RUN edge gives PC=0x18 and TAKEN_CNT increments once.
- Assert RESET during STALL with PC=0x40 -> next edge gives PC=0, TAKEN_CNT=0, state RST. Force PC=0xFFFFFFFC with no branch -> PC=0.
- CNT_W=2, five taken jumps -> TAKEN_CNT reads 1, 2, 3, 3, 3.
